// File: rtl/arbitro_memoria_datos_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// The optional ARB_RR_EN macro switches arbitration to round-robin.
package arbitro_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } estado_t;

  localparam logic PUERTO_CPU = 1'b0;
  localparam logic PUERTO_IO  = 1'b1;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/arbitro_memoria_datos_if.sv
// Requester and memory-side bus of the data-memory arbiter.
// Handshake: reqN is held until the port sees gntN; doneN pulses one cycle when the access completes.
interface arbitro_memoria_datos_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              mem_activa;
  logic              mem_guardar;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [2:0]        estado;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_activa, mem_guardar, mem_dir, mem_din, estado
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_activa, mem_guardar, mem_dir, mem_din, estado
  );
endinterface

// File: rtl/arbitro_memoria_datos_selector.sv
// Combinational winner pick between the two requesters.
// ARB_RR_EN defined: contention goes to the port that did not win last; otherwise port 0 always wins.
module arbitro_selector
  import arbitro_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef ARB_RR_EN
  input  logic last_owner,
`endif
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = PUERTO_CPU;
    if (req0 && req1) begin
`ifdef ARB_RR_EN
      winner = ~last_owner;
`else
      winner = PUERTO_CPU;
`endif
    end else if (req1) begin
      winner = PUERTO_IO;
    end
  end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Two-port arbiter and access sequencer for the 128 x 8 data memory; builds a registered
// single-cycle guardar strobe. Define ARB_RR_EN for round-robin, otherwise fixed priority.
module arbitro_memoria_datos
  import arbitro_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  arbitro_memoria_datos_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_SETUP  = SETUP;
  localparam logic [2:0] S_STROBE = STROBE;
  localparam logic [2:0] S_HOLD   = HOLD;
  localparam logic [2:0] S_DONE   = DONE;

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              activa_q, activa_d;
  logic              guardar_q, guardar_d;
  logic              sel_valid, sel_winner;
  logic              busy;

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;
`endif

  arbitro_selector u_selector (
    .req0       (bus.req0),
    .req1       (bus.req1),
`ifdef ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .valid      (sel_valid),
    .winner     (sel_winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_winner;
          we_d    = sel_winner ? bus.we1    : bus.we0;
          addr_d  = sel_winner ? bus.addr1  : bus.addr0;
          wdata_d = sel_winner ? bus.wdata1 : bus.wdata0;
`ifdef ARB_RR_EN
          last_owner_d = sel_winner;
`endif
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (we_q) begin
          state_d = S_STROBE;
        end else begin
          rdata_d = bus.mem_dout;
          state_d = S_DONE;
        end
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so every pin comes straight off a flop.
    busy      = (state_d != S_IDLE);
    gnt0_d    = busy && (owner_d == PUERTO_CPU);
    gnt1_d    = busy && (owner_d == PUERTO_IO);
    done0_d   = (state_d == S_DONE) && (owner_d == PUERTO_CPU);
    done1_d   = (state_d == S_DONE) && (owner_d == PUERTO_IO);
    activa_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    guardar_d = (state_d == S_STROBE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= PUERTO_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      activa_q  <= 1'b0;
      guardar_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      activa_q  <= activa_d;
      guardar_q <= guardar_d;
    end
  end

`ifdef ARB_RR_EN
  // Resets to port 1 so that port 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_owner_q <= PUERTO_IO;
    else       last_owner_q <= last_owner_d;
  end
`endif

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_activa  = activa_q;
  assign bus.mem_guardar = guardar_q;
  assign bus.mem_dir     = addr_q;
  assign bus.mem_din     = wdata_q;
  assign bus.estado      = state_q;

endmodule
